// File: rtl/video_clk_pkg.sv
// Shared types and rPLL divider codes for the video clock sequencer.
package video_clk_pkg;

  typedef enum logic [1:0] {
    APPLY     = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    FAIL      = 2'd3
  } vpll_state_t;

  localparam logic [5:0] MODE_28M_FBDSEL = 6'b111011;
  localparam logic [5:0] MODE_28M_ODSEL  = 6'b111110;
  localparam logic [5:0] MODE_56M_FBDSEL = 6'b110110;
  localparam logic [5:0] MODE_56M_ODSEL  = 6'b111111;

  // Four-mode default tables alternate 28 MHz / 56 MHz, mode 0 in the low bits.
  localparam logic [23:0] VPLL_DEFAULT_FBDSEL =
    {MODE_56M_FBDSEL, MODE_28M_FBDSEL, MODE_56M_FBDSEL, MODE_28M_FBDSEL};
  localparam logic [23:0] VPLL_DEFAULT_ODSEL =
    {MODE_56M_ODSEL, MODE_28M_ODSEL, MODE_56M_ODSEL, MODE_28M_ODSEL};

endpackage

// File: rtl/vpll_lock_filter.sv
// rPLL LOCK qualifier: two-flop synchroniser, stability counter and loss detector.
module vpll_lock_filter #(
  parameter int LOCK_STABLE = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic clear,
  output logic lock_sync,
  output logic lock_stable,
  output logic lock_lost
);

  localparam int CW = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);

  logic          sync_meta;
  logic          sync_q;
  logic          lock_prev;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      lock_prev <= 1'b0;
    end else begin
      sync_meta <= pll_lock;
      sync_q    <= sync_meta;
      lock_prev <= sync_q;
    end
  end

  // Any low synchronised sample restarts the run of consecutive lock cycles.
  always_ff @(posedge clk) begin
    if (reset || clear || !sync_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt != STABLE_LAST) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign lock_sync   = sync_q;
  assign lock_stable = (stable_cnt == STABLE_LAST);
  assign lock_lost   = !sync_q && !lock_prev;

endmodule

// File: rtl/video_pll_mode_ctrl.sv
// Video rPLL reconfiguration sequencer; define VPLL_RELOCK_EN to re-apply the mode
// automatically after lock loss in RUN (and count those events in relock_count).
module video_pll_mode_ctrl
  import video_clk_pkg::*;
#(
  parameter int                     NUM_MODES      = 4,
  parameter int                     MODE_W         = 2,
  parameter logic [NUM_MODES*6-1:0] FBDSEL_TABLE   = VPLL_DEFAULT_FBDSEL,
  parameter logic [NUM_MODES*6-1:0] ODSEL_TABLE    = VPLL_DEFAULT_ODSEL,
  parameter int                     DEFAULT_MODE   = 0,
  parameter int                     FALLBACK_MODE  = 0,
  parameter int                     PLL_RST_CYCLES = 16,
  parameter int                     LOCK_STABLE    = 256,
  parameter int                     LOCK_TIMEOUT   = 65535,
  parameter int                     MAX_RETRIES    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              pll_lock,
  output logic [5:0]        fbdsel,
  output logic [5:0]        odsel,
  output logic              pll_reset,
  output logic              video_reset,
  output logic [MODE_W-1:0] active_mode,
  output logic              busy,
  output logic              error,
  output logic [7:0]        relock_count
);

  localparam int APPLY_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [APPLY_W-1:0] APPLY_LAST  = APPLY_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [MODE_W-1:0]  DEF_M       = MODE_W'(DEFAULT_MODE);
  localparam logic [MODE_W-1:0]  FALLBACK_M  = MODE_W'(FALLBACK_MODE);
  localparam logic [MODE_W:0]    NUM_MODES_L = (MODE_W + 1)'(NUM_MODES);

  vpll_state_t        state, state_next;
  logic [MODE_W-1:0]  target, target_next;
  logic [RETRY_W-1:0] retries, retries_next;
  logic [APPLY_W-1:0] apply_cnt, apply_cnt_next;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
  logic               error_next;
  logic               req_valid;
  logic               stab_clear;
  logic               lock_sync, lock_stable, lock_lost;
`ifdef VPLL_RELOCK_EN
  logic [7:0]         relock_q, relock_next;
`endif

  // Divider codes sized to the full mode_req range; unused codes never reach target.
  logic [5:0] fbd_rom [2**MODE_W];
  logic [5:0] ods_rom [2**MODE_W];

  for (genvar m = 0; m < 2**MODE_W; m++) begin : g_rom
    if (m < NUM_MODES) begin : g_used
      assign fbd_rom[m] = FBDSEL_TABLE[6*m +: 6];
      assign ods_rom[m] = ODSEL_TABLE[6*m +: 6];
    end else begin : g_unused
      assign fbd_rom[m] = FBDSEL_TABLE[6*DEFAULT_MODE +: 6];
      assign ods_rom[m] = ODSEL_TABLE[6*DEFAULT_MODE +: 6];
    end
  end

  assign req_valid  = ({1'b0, mode_req} < NUM_MODES_L);
  assign stab_clear = (state != WAIT_LOCK);

  vpll_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filter (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .clear       (stab_clear),
    .lock_sync   (lock_sync),
    .lock_stable (lock_stable),
    .lock_lost   (lock_lost)
  );

  always_comb begin
    state_next     = state;
    target_next    = target;
    retries_next   = retries;
    error_next     = error;
    apply_cnt_next = '0;
    tmo_cnt_next   = '0;
`ifdef VPLL_RELOCK_EN
    relock_next    = relock_q;
`endif

    case (state)
      APPLY: begin
        if (apply_cnt == APPLY_LAST) begin
          state_next = WAIT_LOCK;
        end else begin
          apply_cnt_next = apply_cnt + 1'b1;
        end
      end

      // Lock wins over a timeout landing on the same cycle.
      WAIT_LOCK: begin
        if (lock_sync && lock_stable) begin
          state_next = RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          if (retries < RETRY_MAX) begin
            retries_next = retries + 1'b1;
            state_next   = APPLY;
          end else if (target != FALLBACK_M) begin
            target_next  = FALLBACK_M;
            retries_next = '0;
            error_next   = 1'b1;
            state_next   = APPLY;
          end else begin
            error_next = 1'b1;
            state_next = FAIL;
          end
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      // A pending mode change takes priority over a simultaneous lock loss.
      RUN: begin
        retries_next = '0;
        if (req_valid && (mode_req != target)) begin
          target_next = mode_req;
          state_next  = APPLY;
        end else if (lock_lost) begin
`ifdef VPLL_RELOCK_EN
          state_next = APPLY;
          if (relock_q != 8'hFF) begin
            relock_next = relock_q + 8'd1;
          end
`else
          error_next = 1'b1;
`endif
        end
      end

      FAIL: begin
        error_next = 1'b1;
        if (req_valid && (mode_req != target)) begin
          target_next  = mode_req;
          retries_next = '0;
          state_next   = APPLY;
        end
      end

      default: begin
        state_next = APPLY;
      end
    endcase

    if ((state != RUN) && (state_next == RUN) && (target == mode_req)) begin
      error_next = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= APPLY;
      target      <= DEF_M;
      retries     <= '0;
      apply_cnt   <= '0;
      tmo_cnt     <= '0;
      error       <= 1'b0;
      fbdsel      <= fbd_rom[DEF_M];
      odsel       <= ods_rom[DEF_M];
      pll_reset   <= 1'b1;
      video_reset <= 1'b1;
      busy        <= 1'b1;
    end else begin
      state       <= state_next;
      target      <= target_next;
      retries     <= retries_next;
      apply_cnt   <= apply_cnt_next;
      tmo_cnt     <= tmo_cnt_next;
      error       <= error_next;
      fbdsel      <= fbd_rom[target_next];
      odsel       <= ods_rom[target_next];
      pll_reset   <= (state_next == APPLY);
      video_reset <= (state_next != RUN);
      busy        <= (state_next == APPLY) || (state_next == WAIT_LOCK);
    end
  end

  assign active_mode = target;

`ifdef VPLL_RELOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= relock_next;
    end
  end

  assign relock_count = relock_q;
`else
  assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_video_pll_mode_ctrl.sv
// Scoreboard bench for video_pll_mode_ctrl (2 modes, short timings); honours VPLL_RELOCK_EN.
module tb_video_pll_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_req;
  logic       pll_lock;
  logic [5:0] fbdsel, odsel;
  logic       pll_reset, video_reset, busy, error;
  logic [1:0] active_mode;
  logic [7:0] relock_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] mode;
    logic       err;
    logic [7:0] relock;
    int         at;
  } run_exp_t;

  logic [1:0] apply_q[$];
  run_exp_t   run_q[$];
  logic [7:0] exp_relock = 8'd0;

`ifdef VPLL_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  video_pll_mode_ctrl #(
    .NUM_MODES      (2),
    .MODE_W         (2),
    .FBDSEL_TABLE   ({6'b110110, 6'b111011}),
    .ODSEL_TABLE    ({6'b111111, 6'b111110}),
    .DEFAULT_MODE   (0),
    .FALLBACK_MODE  (0),
    .PLL_RST_CYCLES (4),
    .LOCK_STABLE    (8),
    .LOCK_TIMEOUT   (64),
    .MAX_RETRIES    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_req     (mode_req),
    .pll_lock     (pll_lock),
    .fbdsel       (fbdsel),
    .odsel        (odsel),
    .pll_reset    (pll_reset),
    .video_reset  (video_reset),
    .active_mode  (active_mode),
    .busy         (busy),
    .error        (error),
    .relock_count (relock_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] exp_fbd(input logic [1:0] m);
    return (m == 2'd1) ? 6'b110110 : 6'b111011;
  endfunction

  function automatic logic [5:0] exp_ods(input logic [1:0] m);
    return (m == 2'd1) ? 6'b111111 : 6'b111110;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic l);
    mode_req = m;
    pll_lock = l;
  endtask

  task automatic expect_run(input logic [1:0] m, input logic e, input int at);
    run_exp_t x;
    x.mode   = m;
    x.err    = e;
    x.relock = exp_relock;
    x.at     = at;
    run_q.push_back(x);
  endtask

  task automatic wait_until_run(input string tag);
    int n = 0;
    while (video_reset !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput(tag, video_reset, 0);
  endtask

  // Monitor: each pll_reset pulse and each RUN entry consumes one scoreboard entry.
  int   pll_len  = 0;
  logic prev_pll = 1'b1;
  logic prev_vr  = 1'b1;

  always @(negedge clk) begin
    if (prev_pll === 1'b1 && pll_reset === 1'b0) begin
      if (apply_q.size() == 0) begin
        checkOutput("apply_unexpected", 0, 1);
      end else begin
        logic [1:0] m;
        m = apply_q.pop_front();
        checkOutput("apply_len", pll_len, 4);
        checkOutput("apply_mode", active_mode, m);
        checkOutput("apply_fbdsel", fbdsel, exp_fbd(m));
        checkOutput("apply_odsel", odsel, exp_ods(m));
      end
    end
    if (prev_vr === 1'b1 && video_reset === 1'b0) begin
      if (run_q.size() == 0) begin
        checkOutput("run_unexpected", 0, 1);
      end else begin
        run_exp_t x;
        x = run_q.pop_front();
        checkOutput("run_cycle", cyc, x.at);
        checkOutput("run_mode", active_mode, x.mode);
        checkOutput("run_fbdsel", fbdsel, exp_fbd(x.mode));
        checkOutput("run_odsel", odsel, exp_ods(x.mode));
        checkOutput("run_error", error, x.err);
        checkOutput("run_relock", relock_count, x.relock);
      end
    end
    if (reset === 1'b1 || pll_reset !== 1'b1) pll_len = 0;
    else pll_len++;
    prev_pll = pll_reset;
    prev_vr  = video_reset;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m0, l0, d0, n;

    reset = 1'b1;
    applyStimulus(2'd0, 1'b0);
    tick(3);
    checkOutput("rst_pll_reset", pll_reset, 1);
    checkOutput("rst_video_reset", video_reset, 1);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_active_mode", active_mode, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_relock", relock_count, 0);
    checkOutput("rst_fbdsel", fbdsel, 6'b111011);
    checkOutput("rst_odsel", odsel, 6'b111110);

    // Power-up: lock arrives 10 cycles after reset release.
    reset = 1'b0;
    apply_q.push_back(2'd0);
    tick(10);
    l0 = cyc;
    applyStimulus(2'd0, 1'b1);
    expect_run(2'd0, 1'b0, l0 + 10);
    wait_until_run("t1_run");

    // Mode 0 -> 1 with lock held high.
    m0 = cyc;
    applyStimulus(2'd1, 1'b1);
    apply_q.push_back(2'd1);
    expect_run(2'd1, 1'b0, m0 + 13);
    tick(1);
    checkOutput("t2_video_reset", video_reset, 1);
    checkOutput("t2_busy", busy, 1);
    checkOutput("t2_pll_reset", pll_reset, 1);
    checkOutput("t2_fbdsel", fbdsel, 6'b110110);
    checkOutput("t2_odsel", odsel, 6'b111111);
    checkOutput("t2_active_mode", active_mode, 1);
    wait_until_run("t2_run");

    m0 = cyc;
    applyStimulus(2'd0, 1'b1);
    apply_q.push_back(2'd0);
    expect_run(2'd0, 1'b0, m0 + 13);
    tick(1);
    wait_until_run("t2b_run");

    // Mode 1 never locks: three timed-out passes, then fallback to mode 0.
    m0 = cyc;
    applyStimulus(2'd1, 1'b0);
    repeat (3) apply_q.push_back(2'd1);
    apply_q.push_back(2'd0);
    tick(1);
    n = 0;
    while (active_mode !== 2'd0 && n < 400) begin
      tick(1);
      n++;
    end
    checkOutput("t3_fallback_cycle", cyc - m0, 205);
    checkOutput("t3_error", error, 1);
    checkOutput("t3_busy", busy, 1);
    tick(6);
    l0 = cyc;
    applyStimulus(2'd1, 1'b1);
    expect_run(2'd0, 1'b1, l0 + 10);
    apply_q.push_back(2'd1);
    expect_run(2'd1, 1'b0, l0 + 23);
    wait_until_run("t3_run_fallback");
    tick(1);
    wait_until_run("t3_run_mode1");

    // Lock toggles every 4 cycles: stability never reached, timeout retries the mode.
    m0 = cyc;
    apply_q.push_back(2'd0);
    apply_q.push_back(2'd0);
    for (int i = 0; i < 68; i++) begin
      applyStimulus(2'd0, ((i / 4) % 2) == 1);
      tick(1);
    end
    checkOutput("t4_pll_reset_before_tmo", pll_reset, 0);
    checkOutput("t4_busy", busy, 1);
    tick(1);
    checkOutput("t4_pll_reset_at_tmo", pll_reset, 1);
    checkOutput("t4_cycle", cyc - m0, 69);
    l0 = cyc;
    applyStimulus(2'd0, 1'b1);
    expect_run(2'd0, 1'b0, l0 + 12);
    wait_until_run("t4_run");

    // Lock drops for 3 cycles while running.
    d0 = cyc;
    applyStimulus(2'd0, 1'b0);
    if (RELOCK) begin
      exp_relock = 8'd1;
      apply_q.push_back(2'd0);
      expect_run(2'd0, 1'b0, d0 + 16);
    end
    tick(3);
    applyStimulus(2'd0, 1'b1);
    tick(2);
    checkOutput("t5_relock_count", relock_count, RELOCK ? 1 : 0);
    checkOutput("t5_video_reset", video_reset, RELOCK ? 1 : 0);
    checkOutput("t5_error", error, RELOCK ? 0 : 1);
    if (RELOCK) wait_until_run("t5_run");
    tick(4);

    // Out-of-range request is ignored.
    applyStimulus(2'd3, 1'b1);
    tick(5);
    checkOutput("t6_video_reset", video_reset, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_active_mode", active_mode, 0);
    checkOutput("t6_pll_reset", pll_reset, 0);
    checkOutput("t6_error", error, RELOCK ? 0 : 1);

    // Reset asserted during WAIT_LOCK aborts back to the reset state.
    applyStimulus(2'd1, 1'b1);
    apply_q.push_back(2'd1);
    tick(7);
    checkOutput("t6_wait_pll_reset", pll_reset, 0);
    checkOutput("t6_wait_busy", busy, 1);
    reset = 1'b1;
    applyStimulus(2'd0, 1'b1);
    tick(1);
    checkOutput("t6_abort_pll_reset", pll_reset, 1);
    checkOutput("t6_abort_active_mode", active_mode, 0);
    checkOutput("t6_abort_fbdsel", fbdsel, 6'b111011);
    checkOutput("t6_abort_error", error, 0);
    checkOutput("t6_abort_relock", relock_count, 0);
    tick(1);
    reset = 1'b0;
    l0 = cyc;
    exp_relock = 8'd0;
    apply_q.push_back(2'd0);
    expect_run(2'd0, 1'b0, l0 + 12);
    wait_until_run("t6_run");

    tick(5);
    checkOutput("apply_q_drained", apply_q.size(), 0);
    checkOutput("run_q_drained", run_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
